// File: rtl/dtu_ctrl_if.sv
// dtu_ctrl_if: transfer control, sequence-memory and DTU signals of the DTU controller.
interface dtu_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 16
);
    logic              start;
    logic              abort;
    logic [LEN_W-1:0]  seq_len;
    logic [ADDR_W-1:0] base_addr;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              dtu_en;
    logic [31:0]       dtu_din;
    logic              dtu_din_valid;
    logic              dtu_ready;
    logic [1:0]        dtu_dout;
    logic              dtu_dout_valid;
    logic [1:0]        base_out;
    logic              base_valid;
    logic              base_last;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  base_cnt;

    modport master (
        input  start, abort, seq_len, base_addr, mem_rdata, dtu_ready, dtu_dout, dtu_dout_valid,
        output mem_rd, mem_addr, dtu_en, dtu_din, dtu_din_valid, base_out, base_valid, base_last,
               busy, done, base_cnt
    );

    modport slave (
        output start, abort, seq_len, base_addr, mem_rdata, dtu_ready, dtu_dout, dtu_dout_valid,
        input  mem_rd, mem_addr, dtu_en, dtu_din, dtu_din_valid, base_out, base_valid, base_last,
               busy, done, base_cnt
    );
endinterface

// File: rtl/dtu_ctrl.sv
// dtu_ctrl: fetches 16-base words from sequence memory, feeds them to the DTU and forwards
// exactly seq_len returned bases, dropping the padding of a partial last word.
module dtu_ctrl #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 16
) (
    input logic        clk,
    input logic        rst,
    dtu_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, FEED, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d, word_idx_q, word_idx_d, cnt_q, cnt_d, words;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       buf_q, buf_d;
    logic              busy, accept, feed_hs, fwd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            buf_q      <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            buf_q      <= buf_d;
        end
    end

    // abort suppresses every side effect of its cycle so the frozen counters stay consistent
    always_comb begin
        busy       = state_q != IDLE;
        accept     = state_q == IDLE && bus.start && !bus.abort;
        feed_hs    = state_q == FEED && bus.dtu_ready && !bus.abort;
        fwd        = busy && bus.dtu_dout_valid && cnt_q < len_q && !bus.abort;
        words      = (len_q >> 4) + LEN_W'(|len_q[3:0]);
        len_d      = accept ? bus.seq_len : len_q;
        addr_d     = accept ? bus.base_addr : addr_q;
        word_idx_d = accept ? '0 : feed_hs ? word_idx_q + LEN_W'(1) : word_idx_q;
        cnt_d      = accept ? '0 : fwd ? cnt_q + LEN_W'(1) : cnt_q;
        buf_d      = state_q == WAIT ? bus.mem_rdata : buf_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? (bus.seq_len == '0 ? DONE : FETCH) : IDLE;
            FETCH:   state_d = WAIT;
            WAIT:    state_d = FEED;
            FEED:    state_d = feed_hs ? (word_idx_q + LEN_W'(1) < words ? FETCH : DRAIN) : FEED;
            DRAIN:   state_d = cnt_q == len_q ? DONE : DRAIN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.abort) state_d = IDLE;
    end

    always_comb begin
        bus.mem_rd        = state_q == FETCH;
        bus.mem_addr      = bus.mem_rd ? addr_q + ADDR_W'(word_idx_q) : '0;
        bus.dtu_en        = state_q inside {FETCH, WAIT, FEED, DRAIN};
        bus.dtu_din       = buf_q;
        bus.dtu_din_valid = feed_hs;
        bus.base_out      = fwd ? bus.dtu_dout : 2'b00;
        bus.base_valid    = fwd;
        bus.base_last     = fwd && cnt_q == len_q - LEN_W'(1);
        bus.busy          = busy;
        bus.done          = state_q == DONE;
        bus.base_cnt      = cnt_q;
    end
endmodule

// File: tb/tb_dtu_ctrl.sv
// tb_dtu_ctrl: table-driven transfers against a memory model and a 16-bases-per-word DTU model,
// plus hand-written abort and mid-transfer reset sequences.
module tb_dtu_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dtu_ctrl_if #(.ADDR_W(10), .LEN_W(16)) bus();
    dtu_ctrl #(.ADDR_W(10), .LEN_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int len; int addr; int stall; int nf; int a0; int a1; int a2; int nb; int busy;
    } vec_t;

    int n_chk = 0, n_pass = 0;
    int n_base = 0, n_din = 0, n_dbl = 0, n_rdy_err = 0, n_din_err = 0, n_data_err = 0;
    int n_last = 0, n_last_err = 0, n_done = 0, n_busy = 0, n_en = 0;
    logic prev_dv = 1'b0;
    logic [9:0] aq[$];
    logic [1:0] bq[$];
    int b0 = 0, d0 = 0, dn0 = 0, q0 = 0, l0 = 0, e0 = 0, le0 = 0, de0 = 0, db0 = 0, re0 = 0;
    int bz0 = 0, en0 = 0, cur_len = 0;
    logic [9:0] cur_addr = '0;

    function automatic logic [31:0] mem_f(logic [9:0] a);
        return {a, ~a, a ^ 10'h2a5, 2'b01};
    endfunction

    function automatic logic [1:0] sel_base(logic [9:0] a, int i);
        logic [31:0] w;
        w = mem_f(a + 10'(i / 16));
        return w[2*(i%16) +: 2];
    endfunction

    always @(posedge clk) bus.mem_rdata <= bus.mem_rd ? mem_f(bus.mem_addr) : 32'hdeadbeef;

    // DTU model: each accepted word comes back as 16 bases, one per cycle, LSB pair first
    always @(posedge clk) begin
        if (!rst) begin
            bq.delete();
            bus.dtu_dout_valid <= 1'b0;
            bus.dtu_dout       <= 2'b00;
        end else begin
            if (bq.size() > 0) begin
                bus.dtu_dout       <= bq.pop_front();
                bus.dtu_dout_valid <= 1'b1;
            end else bus.dtu_dout_valid <= 1'b0;
            if (bus.dtu_din_valid) for (int k = 0; k < 16; k++) bq.push_back(bus.dtu_din[2*k +: 2]);
        end
    end

    always @(negedge clk) begin
        int i;
        if (bus.base_valid) begin
            i = n_base - b0;
            if (bus.base_out != sel_base(cur_addr, i)) n_data_err++;
            if (bus.base_last != (i == cur_len - 1)) n_last_err++;
            n_base++;
        end else if (bus.base_last) n_last_err++;
        if (bus.base_last) n_last++;
        if (bus.dtu_din_valid) begin
            if (prev_dv) n_dbl++;
            if (!bus.dtu_ready) n_rdy_err++;
            if (bus.dtu_din != mem_f(cur_addr + 10'(n_din - d0))) n_din_err++;
            n_din++;
        end
        prev_dv = bus.dtu_din_valid;
        if (bus.mem_rd) aq.push_back(bus.mem_addr);
        if (bus.done) n_done++;
        if (bus.busy) n_busy++;
        if (bus.dtu_en) n_en++;
    end

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic begin_xfer(int len, int addr, logic rdy);
        b0 = n_base; d0 = n_din; dn0 = n_done; q0 = aq.size(); l0 = n_last; e0 = n_data_err;
        le0 = n_last_err; de0 = n_din_err; db0 = n_dbl; re0 = n_rdy_err; bz0 = n_busy; en0 = n_en;
        cur_len = len; cur_addr = 10'(addr);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.seq_len = 16'(len); bus.base_addr = 10'(addr); bus.dtu_ready = rdy;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_din();
        for (int c = 0; c < 100 && n_din == d0; c++) begin
            @(posedge clk); #1;
        end
        chk("first_word", n_din - d0, 1);
    endtask

    task automatic run(vec_t v);
        int ea[3];
        ea[0] = v.a0; ea[1] = v.a1; ea[2] = v.a2;
        begin_xfer(v.len, v.addr, v.stall == 0);
        for (int c = 1; c < 600 && n_done == dn0; c++) begin
            bus.dtu_ready = c >= v.stall;
            @(posedge clk); #1;
        end
        bus.dtu_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk($sformatf("len%0d_done", v.len), n_done - dn0, 1);
        chk($sformatf("len%0d_fetches", v.len), aq.size() - q0, v.nf);
        for (int j = 0; j < v.nf; j++)
            chk($sformatf("len%0d_addr%0d", v.len, j), aq.size() > q0 + j ? int'(aq[q0+j]) : -1, ea[j]);
        chk($sformatf("len%0d_din_pulses", v.len), n_din - d0, v.nf);
        chk($sformatf("len%0d_bases", v.len), n_base - b0, v.nb);
        chk($sformatf("len%0d_base_cnt", v.len), int'(bus.base_cnt), v.nb);
        chk($sformatf("len%0d_last", v.len), n_last - l0, v.nb > 0 ? 1 : 0);
        chk($sformatf("len%0d_base_data_err", v.len), n_data_err - e0, 0);
        chk($sformatf("len%0d_last_pos_err", v.len), n_last_err - le0, 0);
        chk($sformatf("len%0d_din_data_err", v.len), n_din_err - de0, 0);
        chk($sformatf("len%0d_din_back2back", v.len), n_dbl - db0, 0);
        chk($sformatf("len%0d_din_without_ready", v.len), n_rdy_err - re0, 0);
        if (v.busy >= 0) begin
            chk($sformatf("len%0d_busy_cycles", v.len), n_busy - bz0, v.busy);
            chk($sformatf("len%0d_en_cycles", v.len), n_en - en0, 0);
        end
    endtask

    initial begin
        vec_t vecs[7];
        vecs[0] = '{32, 0, 0, 2, 0, 1, 0, 32, -1};
        vecs[1] = '{20, 5, 0, 2, 5, 6, 0, 20, -1};
        vecs[2] = '{0, 7, 0, 0, 0, 0, 0, 0, 1};
        vecs[3] = '{48, 1023, 0, 3, 1023, 0, 1, 48, -1};
        vecs[4] = '{16, 100, 13, 1, 100, 0, 0, 16, -1};
        vecs[5] = '{1, 3, 0, 1, 3, 0, 0, 1, -1};
        vecs[6] = '{17, 512, 0, 2, 512, 513, 0, 17, -1};
        bus.start = 1'b0; bus.abort = 1'b0; bus.seq_len = '0; bus.base_addr = '0; bus.dtu_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_mem_rd", int'(bus.mem_rd), 0);
        chk("rst_dtu_en", int'(bus.dtu_en), 0);
        chk("rst_base_valid", int'(bus.base_valid), 0);
        chk("rst_base_cnt", int'(bus.base_cnt), 0);
        chk("rst_dtu_din", int'(bus.dtu_din), 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        for (int v = 0; v < 7; v++) run(vecs[v]);

        begin_xfer(48, 0, 1'b1);
        wait_din();
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_dtu_en", int'(bus.dtu_en), 0);
        repeat (60) @(posedge clk);
        #1;
        chk("abort_no_done", n_done - dn0, 0);
        chk("abort_one_word", n_din - d0, 1);
        chk("abort_cnt_frozen", int'(bus.base_cnt), n_base - b0);
        chk("abort_base_data_err", n_data_err - e0, 0);

        begin_xfer(48, 0, 1'b1);
        wait_din();
        rst = 1'b0;
        #1;
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_dtu_en", int'(bus.dtu_en), 0);
        chk("midrst_base_cnt", int'(bus.base_cnt), 0);
        chk("midrst_dtu_din", int'(bus.dtu_din), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk("midrst_no_done", n_done - dn0, 0);
        chk("midrst_idle", int'(bus.busy), 0);
        run('{16, 40, 0, 1, 40, 0, 0, 16, -1});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dtu_ctrl.md
DTU_CTRL -- requirements
Module: dtu_ctrl

Interface
REQ-001: Parameter ADDR_W, default 10, word-address width of the sequence memory.
REQ-002: Parameter LEN_W, default 16, width of the base-count fields.
REQ-003: clk  in  1  sole clock; all state updates on rising edge.
REQ-004: rst  in  1  asynchronous, active-low reset; clears all state immediately when low.
REQ-005: start  in  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-006: abort  in  1  synchronous abort; returns to IDLE from any state.
REQ-007: seq_len  in  LEN_W  number of 2-bit bases to deliver; latched on accepted start.
REQ-008: base_addr  in  ADDR_W  first word address; latched on accepted start.
REQ-009: mem_rd  out  1  memory read strobe; read data is valid exactly one cycle later.
REQ-010: mem_addr  out  ADDR_W  memory word address.
REQ-011: mem_rdata  in  32  memory read data (16 bases per word).
REQ-012: dtu_en  out  1  DTU enable.
REQ-013: dtu_din  out  32  word presented to the DTU.
REQ-014: dtu_din_valid  out  1  one-cycle word strobe to the DTU.
REQ-015: dtu_ready  in  1  level: DTU can accept a word.
REQ-016: dtu_dout  in  2  base from the DTU.
REQ-017: dtu_dout_valid  in  1  dtu_dout is valid.
REQ-018: base_out  out  2  forwarded base.
REQ-019: base_valid  out  1  base_out is valid.
REQ-020: base_last  out  1  asserted with the final forwarded base.
REQ-021: busy  out  1  high in every state except IDLE.
REQ-022: done  out  1  one-cycle pulse on normal completion.
REQ-023: base_cnt  out  LEN_W  number of bases forwarded in the current transfer.

Function
REQ-024: States: IDLE, FETCH, WAIT, FEED, DRAIN, DONE.
REQ-025: IDLE + start: latch seq_len and base_addr, clear word_idx and base_cnt, then go to FETCH; if seq_len==0, go to DONE instead.
REQ-026: Words to issue = ceil(seq_len/16), computed in LEN_W bits with no overflow at the maximum seq_len.
REQ-027: FETCH: mem_rd=1 for exactly one cycle, mem_addr=base_addr+word_idx (mod 2^ADDR_W, wrapping), then go to WAIT.
REQ-028: WAIT: capture mem_rdata into the word buffer, then go to FEED.
REQ-029: FEED: hold until dtu_ready=1; in that cycle drive dtu_din_valid=1 with dtu_din=buffer and increment word_idx.
REQ-030: After a FEED handshake, go to FETCH if words remain, otherwise go to DRAIN.
REQ-031: dtu_din_valid is never high for two consecutive cycles.
REQ-032: dtu_en=1 in FETCH, WAIT, FEED and DRAIN; 0 elsewhere.
REQ-033: In any busy state, while base_cnt<seq_len, each dtu_dout_valid produces base_out=dtu_dout and base_valid=1 in the same cycle (combinational forward), and base_cnt increments at the edge.
REQ-034: base_last=1 with the forwarded base for which base_cnt==seq_len-1.
REQ-035: dtu_dout_valid while base_cnt==seq_len is dropped, with no base_valid; this covers padding bases of a partial last word.
REQ-036: DRAIN: once base_cnt==seq_len, go to DONE.
REQ-037: DONE: done=1 for one cycle, then go to IDLE; base_cnt holds its value until the next accepted start.
REQ-038: start while busy is ignored.
REQ-039: abort has priority over start and over all transitions: go to IDLE, drop dtu_en, no done pulse, base_cnt frozen.
REQ-040: Simultaneous dtu_dout_valid and FEED handshake are both serviced in the same cycle.

Reset
REQ-041: While rst=0: state=IDLE and all outputs 0 (mem_rd, mem_addr, dtu_en, dtu_din, dtu_din_valid, base_out, base_valid, base_last, busy, done, base_cnt).
REQ-042: rst asserted mid-transfer aborts the transfer immediately with no done pulse; operation resumes only on a new start after rst returns to 1.

Verification
REQ-043: seq_len=32, base_addr=0, dtu_ready=1 -> mem_addr 0 then 1, two dtu_din_valid pulses, 32 base_valid, base_last on the 32nd, one done pulse.
REQ-044: seq_len=20 -> 2 words fetched, exactly 20 bases forwarded, remaining 12 DTU bases dropped, base_cnt=20.
REQ-045: seq_len=0 -> busy high for one cycle, done pulses, mem_rd and dtu_en never asserted.
REQ-046: base_addr=2^ADDR_W-1, seq_len=48 -> mem_addr sequence max, 0, 1.
REQ-047: dtu_ready held low 10 cycles in FEED -> dtu_din_valid delayed, dtu_din stable, no word lost.
REQ-048: abort, then separately rst=0, each applied after the first word -> IDLE, dtu_en=0, no done; a new start with seq_len=16 completes normally.
